dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit between the CPU memory stage and `dmem`; the only block that drives `dmem`'s `clk`/`write_enable`/`addr`/`writedata`/`readdata` interface.
- CPU side: byte-addressed, with byte and word sizes and sign/zero-extended loads. Side facing `dmem`: 16-bit word-addressed, combinational read, write on posedge `clk`.
- Byte stores use a 2-cycle read-modify-write. All responses are registered.

Parameters:
- `N`, 16, data width and CPU byte-address width; `dmem` word-address width is also `N`.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  CPU request present
- `req_ready`  out  1  LSU can accept; transfer when `req_valid` and `req_ready` are both high at posedge
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  1  0 = byte, 1 = word (16 b)
- `req_signed`  in  1  byte load: 1 = sign-extend, 0 = zero-extend; ignored otherwise
- `req_addr`  in  N  byte address
- `req_wdata`  in  N  store data; byte store uses `[7:0]`
- `resp_valid`  out  1  one-cycle pulse, response valid
- `resp_rdata`  out  N  load result; 0 for stores and errors
- `resp_err`  out  1  misaligned word access
- `dmem_addr`  out  N  word address to `dmem`
- `dmem_write_enable`  out  1  `dmem` write strobe
- `dmem_writedata`  out  N  `dmem` write data
- `dmem_readdata`  in  N  `dmem` combinational read data

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- While `rst_n` = 0:
  - state = `IDLE`.
  - `resp_valid`, `resp_err`, `resp_rdata`, `dmem_write_enable`, `req_ready` = 0.
  - All internal registers cleared.
- Reset mid-RMW: the pending write is dropped, the `dmem` word is unchanged, and no response is issued.
- Word address: `dmem_addr` = `{1'b0, req_addr[N-1:1]}` in `IDLE`, and the latched word address in `RMW`.
- Endianness: little-endian. `addr[0]` = 0 selects bits `[7:0]`; `addr[0]` = 1 selects bits `[15:8]`.
- FSM has two states: `IDLE` and `RMW`.
- `IDLE`, general:
  - `req_ready` = 1.
  - `dmem_write_enable` = `req_valid` & `req_write` & `req_size` & ~`req_addr[0]`, so a word store is written at the accepting edge.
  - `dmem_writedata` = `req_wdata`.
- `IDLE`, on accept:
  - Word load, aligned: `resp_rdata` <= `dmem_readdata`; `resp_valid` = 1 next cycle. Latency 1.
  - Word store, aligned: `dmem` written at the accept edge; `resp_valid` = 1 next cycle with `resp_rdata` = 0. Latency 1.
  - Word access with `addr[0]` = 1: no write; next cycle `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0.
  - Byte load: select the byte of `dmem_readdata` by `addr[0]`, then extend per `req_signed`; registered; latency 1.
  - Byte store:
    - Latch the merged word: `dmem_readdata` with the selected byte replaced by `req_wdata[7:0]`.
    - Latch the word address.
    - Go to `RMW`.
- `RMW`:
  - `req_ready` = 0.
  - `dmem_write_enable` = 1, `dmem_writedata` = merged word, `dmem_addr` = latched address.
  - Next state `IDLE`; `resp_valid` = 1 the following cycle, so byte-store latency is 2.
- Throughput:
  - Back-to-back requests are accepted every cycle in `IDLE`.
  - A `resp_valid` pulse may coincide with the next accept.
  - The CPU holds its request stable while `req_ready` = 0.
- `resp_err` is 0 whenever `resp_valid` is 0. `resp_rdata` holds its value between pulses.

Decomposition:
- Package `lsu_pkg`:
  - `typedef enum logic {IDLE, RMW} lsu_state_t`
  - `localparam SIZE_BYTE = 1'b0, SIZE_WORD = 1'b1`
- Combinational sub-module `load_align`:
  - Inputs: word, `addr[0]`, `signed`.
  - Output: extended N-bit result.
  - Reused for byte select in the merge path.

Test Plan:
- Word store `0xABCD` @`0x0004`, then word load @`0x0004` → `dmem` word 2 = `0xABCD`; `resp_rdata` = `0xABCD`; each `resp_valid` 1 cycle after accept.
- Byte store `0x12` @`0x0005` → `req_ready` low exactly 1 cycle; word 2 = `0x12CD`; `resp_valid` 2 cycles after accept. Then unsigned byte load @`0x0005` → `0x0012`.
- Byte store `0x80` @`0x0004`, then signed byte load @`0x0004` → `0xFF80`; unsigned byte load → `0x0080`; word 2 = `0x1280`.
- Word store `0x5555` @`0x0003` → `resp_err` = 1, `resp_rdata` = 0, `dmem_write_enable` never high; word 1 unchanged.
- Byte store `0x77` @`0x0004`, with `rst_n` pulled low during the `RMW` cycle → word 2 stays `0x1280`, no `resp_valid`; after release, `req_ready` = 1 and a word load returns `0x1280`.
- Four back-to-back word loads @`0x0000`, `0x0002`, `0x0004`, `0x0006` → four consecutive `resp_valid` pulses, data in order, `req_ready` high throughout.

Source files
------------

// File: rtl/lsu_pkg.sv
`timescale 1ns/1ps
// Shared types and encodings for the data-memory load/store unit.
package lsu_pkg;

  typedef enum logic {IDLE = 1'b0, RMW = 1'b1} lsu_state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/dmem_lsu_load_align.sv
`timescale 1ns/1ps
// Picks one byte of a little-endian 16-bit word and extends it to N bits.
module load_align #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_word,
  input  logic         i_sel,
  input  logic         i_signed,
  output logic [N-1:0] o_data
);

  logic [7:0] w_byte;

  assign w_byte = i_sel ? i_word[15:8] : i_word[7:0];
  assign o_data = {{(N-8){i_signed & w_byte[7]}}, w_byte};

endmodule

// File: rtl/dmem_lsu.sv
`timescale 1ns/1ps
// Load/store unit: byte-addressed CPU requests onto a word-addressed dmem,
// with a two-cycle read-modify-write for byte stores.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic         req_size,
  input  logic         req_signed,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic [N-1:0] dmem_addr,
  output logic         dmem_write_enable,
  output logic [N-1:0] dmem_writedata,
  input  logic [N-1:0] dmem_readdata
);

  lsu_state_t   r_state;
  logic         r_ready;
  logic [N-1:0] r_addr;
  logic [N-1:0] r_merged;
  logic         r_resp_valid;
  logic         r_resp_err;
  logic [N-1:0] r_resp_rdata;

  logic         w_accept;
  logic         w_misalign;
  logic         w_in_rmw;
  logic [N-1:0] w_word_addr;
  logic [N-1:0] w_load;
  logic [N-1:0] w_keep;
  logic [N-1:0] w_merged;

  // Byte the load returns.
  load_align #(.N(N)) u_load (
    .i_word   (dmem_readdata),
    .i_sel    (req_addr[0]),
    .i_signed (req_signed),
    .o_data   (w_load)
  );

  // Byte a byte store must preserve (the opposite lane), zero-extended.
  load_align #(.N(N)) u_keep (
    .i_word   (dmem_readdata),
    .i_sel    (~req_addr[0]),
    .i_signed (1'b0),
    .o_data   (w_keep)
  );

  assign w_word_addr = {1'b0, req_addr[N-1:1]};
  assign w_merged    = req_addr[0] ? ({req_wdata[7:0], 8'h00} | w_keep)
                                   : ((w_keep << 8) | {8'h00, req_wdata[7:0]});
  assign w_in_rmw    = (r_state == RMW);
  assign w_accept    = r_ready & req_valid;
  assign w_misalign  = (req_size == SIZE_WORD) & req_addr[0];

  // r_ready is low in reset and during RMW, which also gates the write strobe.
  assign req_ready         = r_ready;
  assign dmem_addr         = w_in_rmw ? r_addr   : w_word_addr;
  assign dmem_writedata    = w_in_rmw ? r_merged : req_wdata;
  assign dmem_write_enable = w_in_rmw |
                             (r_ready & req_valid & req_write & req_size & ~req_addr[0]);

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_addr       <= '0;
      r_merged     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (req_size == SIZE_WORD) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_misalign;
              r_resp_rdata <= (w_misalign | req_write) ? '0 : dmem_readdata;
            end else if (req_write) begin
              r_merged <= w_merged;
              r_addr   <= w_word_addr;
              r_ready  <= 1'b0;
              r_state  <= RMW;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_load;
            end
          end
        end
        RMW: begin
          r_state      <= IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
`timescale 1ns/1ps
// Scoreboard bench for dmem_lsu with a behavioural memory model.
module tb_dmem_lsu;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic         req_size = 1'b0;
  logic         req_signed = 1'b0;
  logic [N-1:0] req_addr = '0;
  logic [N-1:0] req_wdata = '0;
  logic         resp_valid;
  logic [N-1:0] resp_rdata;
  logic         resp_err;
  logic [N-1:0] dmem_addr;
  logic         dmem_write_enable;
  logic [N-1:0] dmem_writedata;
  logic [N-1:0] dmem_readdata;

  dmem_lsu #(.N(N)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_size          (req_size),
    .req_signed        (req_signed),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_err          (resp_err),
    .dmem_addr         (dmem_addr),
    .dmem_write_enable (dmem_write_enable),
    .dmem_writedata    (dmem_writedata),
    .dmem_readdata     (dmem_readdata)
  );

  always #5 clk = ~clk;

  // dmem: combinational read, write on posedge
  logic [15:0] mem [0:65535];
  assign dmem_readdata = mem[dmem_addr];
  always @(posedge clk) if (dmem_write_enable) mem[dmem_addr] <= dmem_writedata;

  int cyc = 0;
  int we_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (dmem_write_enable) we_cnt <= we_cnt + 1;

  typedef struct {
    logic [15:0] d;
    bit          e;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_x;
  logic [15:0] ref_mem [0:63];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: expected response and memory effect from the architectural rules.
  function automatic void model(input bit wr, input bit sz, input bit sg,
                                input logic [15:0] a, input logic [15:0] d,
                                output logic [15:0] rd, output bit e, output int lat);
    int          wi;
    int          sh;
    logic [15:0] w;
    logic [15:0] b;
    wi  = int'(a >> 1) % 64;
    sh  = a[0] ? 8 : 0;
    w   = ref_mem[wi];
    e   = 1'b0;
    rd  = 16'h0000;
    lat = 1;
    if (sz) begin
      if (a[0]) e = 1'b1;
      else if (wr) ref_mem[wi] = d;
      else rd = w;
    end else if (wr) begin
      lat = 2;
      ref_mem[wi] = (w & ~(16'h00FF << sh)) | ({8'h00, d[7:0]} << sh);
    end else begin
      b = (w >> sh) & 16'h00FF;
      if (sg && b >= 16'h0080) b = b + 16'hFF00;
      rd = b;
    end
  endfunction

  task automatic issue(input bit wr, input bit sz, input bit sg,
                       input logic [15:0] a, input logic [15:0] d, output int stalls);
    exp_t x;
    int   lat;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    stalls     = 0;
    while (!req_ready && stalls < 8) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      model(wr, sz, sg, a, d, x.d, x.e, lat);
      x.at = cyc + lat;
      sb.push_back(x);
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every response must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else begin
          m_x = sb.pop_front();
          chk("rdata", resp_rdata, m_x.d);
          chk("err", resp_err, m_x.e);
          chk("latency", cyc, m_x.at);
        end
      end else begin
        chk("err_without_valid", resp_err, 1'b0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    int          w0;
    logic [15:0] v;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 64; i++) begin
      v = 16'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    // A would-be word store held during reset must not reach dmem.
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 16'h0000;
    req_wdata = 16'hDEAD;
    #20;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 16'h0000);
    chk("rst_we", dmem_write_enable, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    req_valid = 1'b0;
    #7 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", req_ready, 1'b1);
    chk("mem0_after_reset", mem[0], ref_mem[0]);

    // Word store then word load
    issue(1, 1, 0, 16'h0004, 16'hABCD, st);
    issue(0, 1, 0, 16'h0004, 16'h0000, st);
    drain();
    chk("mem2_word_store", mem[2], 16'hABCD);

    // Byte store upper lane: one stall cycle, then unsigned reload
    issue(1, 0, 0, 16'h0005, 16'h0012, st);
    chk("ready_low_in_rmw", req_ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_back_after_rmw", req_ready, 1'b1);
    drain();
    chk("mem2_byte_hi", mem[2], 16'h12CD);
    issue(0, 0, 0, 16'h0005, 16'h0000, st);
    drain();

    // Byte store lower lane, signed and unsigned reloads
    issue(1, 0, 0, 16'h0004, 16'h0080, st);
    issue(0, 0, 1, 16'h0004, 16'h0000, st);
    issue(0, 0, 0, 16'h0004, 16'h0000, st);
    drain();
    chk("mem2_byte_lo", mem[2], 16'h1280);

    // Misaligned word store: error, no write
    w0 = we_cnt;
    issue(1, 1, 0, 16'h0003, 16'h5555, st);
    drain();
    chk("misalign_no_we", we_cnt, w0);
    chk("misalign_mem1", mem[1], ref_mem[1]);

    // Reset during the RMW cycle drops the write and the response
    chk("ready_pre_rmw", req_ready, 1'b1);
    req_write = 1'b1; req_size = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0004; req_wdata = 16'h0077; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rmw_reset_mem2", mem[2], 16'h1280);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rmw_reset", req_ready, 1'b1);
    issue(0, 1, 0, 16'h0004, 16'h0000, st);
    drain();

    // Back-to-back word loads
    for (int i = 0; i < 4; i++) begin
      issue(0, 1, 0, 16'(2 * i), 16'h0000, st);
      chk("b2b_stall", st, 0);
    end
    drain();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom_range(0, 127)), 16'($urandom), st);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
